// File: rtl/aes_dec_top.sv
// rtl/aes_dec_top.sv - iterative AES-128 decryptor, two passes compared for fault detection
module aes_dec_top (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] key,
  input  logic [127:0] ciphertext,
  output logic         busy,
  output logic         done,
  output logic [127:0] plaintext,
  output logic         fault_flag
);

  typedef enum logic [2:0] {IDLE, KEXP, PASS0, PASS1, CHECK} state_e;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // a^254 == a^-1 in GF(2^8); zero maps to zero as AES requires
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] r;
    sq = a;
    r  = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] a, input int n);
    logic [15:0] t;
    t = {a, a} << n;
    return t[15:8];
  endfunction

  function automatic logic [7:0] aes_sbox(input logic [7:0] a);
    logic [7:0] b;
    b = gf_inv(a);
    return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] aes_inv_sbox(input logic [7:0] a);
    return gf_inv(rotl8(a, 1) ^ rotl8(a, 3) ^ rotl8(a, 6) ^ 8'h05);
  endfunction

  // byte i of the block sits at bits [127-8i -: 8]; column-major, byte = row + 4*col
  function automatic logic [127:0] inv_shift_sub(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(r+4*c) -: 8] = aes_inv_sbox(s[127-8*(r+4*((c-r+4)%4)) -: 8]);
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
      o[119-32*c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
      o[111-32*c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
      o[103-32*c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
    end
    return o;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] i);
    case (i)
      4'd0:    return 8'h01;
      4'd1:    return 8'h02;
      4'd2:    return 8'h04;
      4'd3:    return 8'h08;
      4'd4:    return 8'h10;
      4'd5:    return 8'h20;
      4'd6:    return 8'h40;
      4'd7:    return 8'h80;
      4'd8:    return 8'h1b;
      default: return 8'h36;
    endcase
  endfunction

  function automatic logic [127:0] next_rk(input logic [127:0] rk, input logic [7:0] rc);
    logic [31:0] t, w0, w1, w2, w3;
    t  = {aes_sbox(rk[23:16]), aes_sbox(rk[15:8]), aes_sbox(rk[7:0]), aes_sbox(rk[31:24])}
         ^ {rc, 24'h0};
    w0 = rk[127:96] ^ t;
    w1 = rk[95:64] ^ w0;
    w2 = rk[63:32] ^ w1;
    w3 = rk[31:0] ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  state_e       fsm_q, fsm_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [127:0] state_reg, state_d;
  logic [127:0] res0_reg, res0_d;
  logic [127:0] pt_q, pt_d;
  logic         fault_q, fault_d;
  logic         done_q, done_d;
  logic [127:0] ct_q;
  logic [127:0] rk_q [0:10];
  logic [3:0]   rk_idx;
  logic [127:0] round_ark;
  logic [127:0] round_res;

  // round keys and the ciphertext are rebuilt on every request, so they carry no reset
  always_ff @(posedge clk) begin
    if (fsm_q == IDLE && start) begin
      rk_q[0] <= key;
      ct_q    <= ciphertext;
    end
    if (fsm_q == KEXP) begin
      rk_q[cnt_q + 4'd1] <= next_rk(rk_q[cnt_q], rcon(cnt_q));
    end
  end

  assign rk_idx    = (cnt_q == 4'd0) ? 4'd10 : 4'd10 - cnt_q;
  assign round_ark = inv_shift_sub(state_reg) ^ rk_q[rk_idx];
  assign round_res = (cnt_q == 4'd10) ? round_ark : inv_mix_columns(round_ark);

  always_comb begin
    fsm_d   = fsm_q;
    cnt_d   = cnt_q;
    state_d = state_reg;
    res0_d  = res0_reg;
    pt_d    = pt_q;
    fault_d = fault_q;
    done_d  = 1'b0;
    case (fsm_q)
      IDLE: begin
        if (start) begin
          fsm_d = KEXP;
          cnt_d = 4'd0;
        end
      end
      KEXP: begin
        if (cnt_q == 4'd9) begin
          fsm_d = PASS0;
          cnt_d = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      PASS0, PASS1: begin
        state_d = (cnt_q == 4'd0) ? (ct_q ^ rk_q[10]) : round_res;
        if (cnt_q == 4'd10) begin
          cnt_d = 4'd0;
          if (fsm_q == PASS0) begin
            res0_d = round_res;
            fsm_d  = PASS1;
          end else begin
            fsm_d = CHECK;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      CHECK: begin
        if (state_reg == res0_reg) begin
          pt_d    = state_reg;
          fault_d = 1'b0;
        end else begin
          pt_d    = 128'h0;
          fault_d = 1'b1;
        end
        done_d = 1'b1;
        fsm_d  = IDLE;
      end
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q     <= IDLE;
      cnt_q     <= 4'd0;
      state_reg <= 128'h0;
      res0_reg  <= 128'h0;
      pt_q      <= 128'h0;
      fault_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      fsm_q     <= fsm_d;
      cnt_q     <= cnt_d;
      state_reg <= state_d;
      res0_reg  <= res0_d;
      pt_q      <= pt_d;
      fault_q   <= fault_d;
      done_q    <= done_d;
    end
  end

  assign busy       = (fsm_q != IDLE);
  assign done       = done_q;
  assign plaintext  = pt_q;
  assign fault_flag = fault_q;

endmodule

// File: tb/tb_aes_dec_top.sv
// tb/tb_aes_dec_top.sv - scoreboard bench for aes_dec_top against a reference AES encryptor
module tb_aes_dec_top;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [127:0] key;
  logic [127:0] ciphertext;
  logic         busy;
  logic         done;
  logic [127:0] plaintext;
  logic         fault_flag;

  aes_dec_top dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .key        (key),
    .ciphertext (ciphertext),
    .busy       (busy),
    .done       (done),
    .plaintext  (plaintext),
    .fault_flag (fault_flag)
  );

  typedef struct packed {
    logic [127:0] pt;
    logic         fault;
    logic [31:0]  cyc;
  } exp_t;

  exp_t       sb_q [$];
  int         n_checks;
  int         n_fail;
  int         cyc;
  logic       done_prev;
  logic [7:0] sbox_t [256];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk128(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] rol(input logic [7:0] a, input int n);
    logic [15:0] t;
    t = {a, a} << n;
    return t[15:8];
  endfunction

  // S-box by walking generator 3 and its inverse together
  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b00};
      q = q ^ {q[3:0], 4'h0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ rol(q, 1) ^ rol(q, 2) ^ rol(q, 3) ^ rol(q, 4);
      sbox_t[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sbox_t[0] = 8'h63;
  endtask

  function automatic logic [127:0] ref_encrypt(input logic [127:0] k, input logic [127:0] p);
    logic [31:0]  w [44];
    logic [31:0]  t;
    logic [7:0]   rc;
    logic [7:0]   s [16];
    logic [7:0]   n [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] o;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = {sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]], sbox_t[t[31:24]]} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int i = 0; i < 16; i++) s[i] = p[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
    for (int r = 1; r <= 10; r++) begin
      for (int c = 0; c < 4; c++)
        for (int row = 0; row < 4; row++)
          n[row+4*c] = sbox_t[s[row+4*((c+row)%4)]];
      if (r < 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = n[4*c]; a1 = n[4*c+1]; a2 = n[4*c+2]; a3 = n[4*c+3];
          n[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          n[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          n[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          n[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
      end
      for (int i = 0; i < 16; i++) s[i] = n[i] ^ w[4*r + i/4][31-8*(i%4) -: 8];
    end
    o = '0;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
    return o;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  always @(negedge clk) begin
    if (rst_n && done) begin
      chk1("busy_during_done", busy, 1'b0);
      chk1("done_width", done_prev, 1'b0);
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: done at cycle %0d with no request pending", cyc);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk128("plaintext", plaintext, e.pt);
        chk1("fault_flag", fault_flag, e.fault);
        chk_int("done_cycle", cyc, int'(e.cyc));
      end
    end
    done_prev <= rst_n ? done : 1'b0;
  end

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget && sb_q.size() != 0; i++) @(negedge clk);
    if (sb_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL done_timeout: %0d responses still pending", sb_q.size());
      sb_q.delete();
    end
  endtask

  // fault_rel / abort_rel: cycle after the start edge at which to act, 0 = never
  task automatic run_req(input logic [127:0] k, input logic [127:0] c, input logic [127:0] p,
                         input logic exp_fault, input int fault_rel, input int abort_rel,
                         input bit hassle);
    int           e0, rel;
    logic [127:0] v;
    exp_t         e;
    @(negedge clk);
    key        = k;
    ciphertext = c;
    start      = 1'b1;
    e0         = cyc + 1;
    if (abort_rel == 0) begin
      e.pt    = exp_fault ? 128'h0 : p;
      e.fault = exp_fault;
      e.cyc   = e0 + 33;
      sb_q.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
    rel   = 0;
    while (rel < 33) begin
      @(negedge clk);
      rel = cyc - e0;
      if (hassle) begin
        start = (rel == 5 || rel == 20);
        if (rel == 10) begin
          key        = rnd128();
          ciphertext = rnd128();
        end
      end
      if (rel == fault_rel) begin
        v = dut.state_reg ^ 128'h1;
        force dut.state_reg = v;
        @(posedge clk);
        #1;
        release dut.state_reg;
      end
      if (abort_rel != 0 && rel == abort_rel) begin
        rst_n = 1'b0;
        #1;
        chk1("abort_busy", busy, 1'b0);
        chk1("abort_done", done, 1'b0);
        chk1("abort_fault", fault_flag, 1'b0);
        chk128("abort_plaintext", plaintext, 128'h0);
        chk128("abort_state_reg", dut.state_reg, 128'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        return;
      end
    end
    start = 1'b0;
    wait_drain(10);
    repeat (3) @(negedge clk);
    chk128("plaintext_hold", plaintext, exp_fault ? 128'h0 : p);
    if (hassle) repeat (40) @(negedge clk);
  endtask

  task automatic run_b2b(input logic [127:0] k, input logic [127:0] c, input logic [127:0] p);
    int   e0;
    exp_t e;
    @(negedge clk);
    key        = k;
    ciphertext = c;
    start      = 1'b1;
    e0         = cyc + 1;
    for (int i = 0; i < 3; i++) begin
      e.pt    = p;
      e.fault = 1'b0;
      e.cyc   = e0 + 33 + 34 * i;
      sb_q.push_back(e);
    end
    while (cyc < e0 + 68) @(negedge clk);
    start = 1'b0;
    wait_drain(60);
    repeat (40) @(negedge clk);
  endtask

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;

  initial begin
    logic [127:0] k, p;
    n_checks   = 0;
    n_fail     = 0;
    rst_n      = 1'b0;
    start      = 1'b0;
    key        = '0;
    ciphertext = '0;
    build_sbox();
    repeat (3) @(negedge clk);
    chk1("reset_busy", busy, 1'b0);
    chk1("reset_done", done, 1'b0);
    chk1("reset_fault", fault_flag, 1'b0);
    chk128("reset_plaintext", plaintext, 128'h0);
    rst_n = 1'b1;
    @(negedge clk);

    run_req(C1_KEY, C1_CT, C1_PT, 1'b0, 0, 0, 1'b0);
    run_req(B_KEY, B_CT, B_PT, 1'b0, 0, 0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      k = rnd128();
      p = rnd128();
      run_req(k, ref_encrypt(k, p), p, 1'b0, 0, 0, 1'b0);
    end
    run_req(C1_KEY, C1_CT, C1_PT, 1'b1, 14, 0, 1'b0);
    run_req(B_KEY, B_CT, B_PT, 1'b1, 26, 0, 1'b0);
    run_req(B_KEY, B_CT, B_PT, 1'b0, 0, 0, 1'b0);
    k = rnd128();
    p = rnd128();
    run_req(k, ref_encrypt(k, p), p, 1'b0, 0, 0, 1'b1);
    run_b2b(C1_KEY, C1_CT, C1_PT);
    k = rnd128();
    p = rnd128();
    run_req(k, ref_encrypt(k, p), p, 1'b0, 0, 15, 1'b0);
    run_req(C1_KEY, C1_CT, C1_PT, 1'b0, 0, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
